// File: rtl/msdap_out_serializer.sv
// Per-channel parallel-to-serial output stage: one shifter plus a one-deep holding buffer, words back-to-back.
// Optional sticky overrun flag enabled by defining MSDAP_SER_OVF_FLAG_EN.
module msdap_out_serializer #(
   parameter int DW        = 40,
   parameter int NCH       = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              load,
   input  logic [NCH*DW-1:0] data_in,
   input  logic [NCH-1:0]    ch_en,
   output logic              ready,
   output logic              outready,
   output logic [NCH-1:0]    sout,
   output logic [NCH-1:0]    wsen,
   output logic              word_end,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NCH*DW-1:0]   shreg_q, shreg_d, shifted;
   logic [NCH*DW-1:0]   buf_q, buf_d;
   logic [NCH-1:0]      en_q, en_d, buf_en_q, buf_en_d, cur_bit;
   logic                buf_full_q, buf_full_d;
   logic                accept;

   // Each channel shifts independently; the outgoing bit sits at the word edge chosen by MSB_FIRST.
   always_comb begin
      shifted = '0;
      cur_bit = '0;
      for (int i = 0; i < NCH; i++) begin
         if (MSB_FIRST != 0) begin
            cur_bit[i]          = shreg_q[i*DW + DW - 1];
            shifted[i*DW +: DW] = {shreg_q[i*DW +: DW-1], 1'b0};
         end else begin
            cur_bit[i]          = shreg_q[i*DW];
            shifted[i*DW +: DW] = {1'b0, shreg_q[i*DW + 1 +: DW-1]};
         end
      end
   end

   assign outready = (state_q == SHIFT);
   assign word_end = outready && (cnt_q == LAST);
   assign ready    = ~buf_full_q;
   assign accept   = load & ready;
   assign wsen     = en_q & {NCH{outready}};
   assign sout     = cur_bit & wsen;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      en_d       = en_q;
      buf_d      = buf_q;
      buf_en_d   = buf_en_q;
      buf_full_d = buf_full_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = data_in;
               en_d    = ch_en;
            end
         end
         SHIFT: begin
            if (word_end) begin
               // Last bit: refill from buffer first, then from a same-cycle load, else drain.
               cnt_d = '0;
               if (buf_full_q) begin
                  shreg_d    = buf_q;
                  en_d       = buf_en_q;
                  buf_full_d = 1'b0;
               end else if (accept) begin
                  shreg_d = data_in;
                  en_d    = ch_en;
               end else begin
                  state_d = IDLE;
                  en_d    = '0;
               end
            end else begin
               cnt_d   = cnt_q + 1'b1;
               shreg_d = shifted;
               if (accept) begin
                  buf_d      = data_in;
                  buf_en_d   = ch_en;
                  buf_full_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sclk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shreg_q    <= '0;
         en_q       <= '0;
         buf_q      <= '0;
         buf_en_q   <= '0;
         buf_full_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shreg_q    <= shreg_d;
         en_q       <= en_d;
         buf_q      <= buf_d;
         buf_en_q   <= buf_en_d;
         buf_full_q <= buf_full_d;
      end
   end

`ifdef MSDAP_SER_OVF_FLAG_EN
   logic ovf_q;

   // A rejected load sets the flag; setting wins over a simultaneous clear.
   always_ff @(posedge sclk or negedge reset) begin
      if (!reset)
         ovf_q <= 1'b0;
      else if (load && !ready)
         ovf_q <= 1'b1;
      else if (ovf_clr)
         ovf_q <= 1'b0;
   end

   assign ovf = ovf_q;
`else
   assign ovf = ovf_clr & 1'b0;
`endif

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Scoreboard bench for msdap_out_serializer: a 40-bit stereo MSB-first instance and a 16-bit mono LSB-first instance.
module tb_msdap_out_serializer;

   logic sclk = 1'b0;
   always #5 sclk = ~sclk;

   logic rst_n;

   logic        a_load, a_ready, a_outready, a_we, a_ovf, a_ovf_clr;
   logic [79:0] a_data;
   logic [1:0]  a_en, a_sout, a_wsen;

   logic        b_load, b_ready, b_outready, b_we, b_ovf, b_ovf_clr;
   logic [15:0] b_data;
   logic [0:0]  b_en, b_sout, b_wsen;

`ifdef MSDAP_SER_OVF_FLAG_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   msdap_out_serializer #(.DW(40), .NCH(2), .MSB_FIRST(1)) u_a (
      .sclk(sclk), .reset(rst_n), .load(a_load), .data_in(a_data), .ch_en(a_en),
      .ready(a_ready), .outready(a_outready), .sout(a_sout), .wsen(a_wsen),
      .word_end(a_we), .ovf(a_ovf), .ovf_clr(a_ovf_clr));

   msdap_out_serializer #(.DW(16), .NCH(1), .MSB_FIRST(0)) u_b (
      .sclk(sclk), .reset(rst_n), .load(b_load), .data_in(b_data), .ch_en(b_en),
      .ready(b_ready), .outready(b_outready), .sout(b_sout), .wsen(b_wsen),
      .word_end(b_we), .ovf(b_ovf), .ovf_clr(b_ovf_clr));

   typedef struct {logic [1:0] sout; logic [1:0] wsen; logic we;} exp_a_t;
   typedef struct {logic sout; logic wsen; logic we;} exp_b_t;

   exp_a_t qa[$];
   exp_b_t qb[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive a word onto instance A; push its expected bit stream only when it will be accepted.
   task automatic a_drive(input logic [39:0] l, input logic [39:0] r, input logic [1:0] en, input bit push);
      exp_a_t e;
      a_load = 1'b1;
      a_data = {r, l};
      a_en   = en;
      if (push) begin
         for (int k = 0; k < 40; k++) begin
            e.sout[0] = l[39-k] & en[0];
            e.sout[1] = r[39-k] & en[1];
            e.wsen    = en;
            e.we      = (k == 39);
            qa.push_back(e);
         end
      end
   endtask

   task automatic b_drive(input logic [15:0] w);
      exp_b_t e;
      b_load = 1'b1;
      b_data = w;
      b_en   = 1'b1;
      for (int k = 0; k < 16; k++) begin
         e.sout = w[k];
         e.wsen = 1'b1;
         e.we   = (k == 15);
         qb.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   always @(negedge sclk) begin
      if (a_outready === 1'b1) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_unexpected_bit actual=shifting required=idle at %0t", $time);
         end else begin
            exp_a_t e;
            e = qa.pop_front();
            chk("a_sout", 64'(a_sout), 64'(e.sout));
            chk("a_wsen", 64'(a_wsen), 64'(e.wsen));
            chk("a_word_end", 64'(a_we), 64'(e.we));
         end
      end
      if (b_outready === 1'b1) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_unexpected_bit actual=shifting required=idle at %0t", $time);
         end else begin
            exp_b_t e;
            e = qb.pop_front();
            chk("b_sout", 64'(b_sout), 64'(e.sout));
            chk("b_wsen", 64'(b_wsen), 64'(e.wsen));
            chk("b_word_end", 64'(b_we), 64'(e.we));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, bad, ones;
      logic first;
      rst_n = 1'b0;
      a_load = 1'b0; a_data = '0; a_en = '0; a_ovf_clr = 1'b0;
      b_load = 1'b0; b_data = '0; b_en = '0; b_ovf_clr = 1'b0;
      repeat (2) step();

      chk("rst_ready", 64'(a_ready), 64'd1);
      chk("rst_outready", 64'(a_outready), 64'd0);
      chk("rst_sout", 64'(a_sout), 64'd0);
      chk("rst_wsen", 64'(a_wsen), 64'd0);
      chk("rst_word_end", 64'(a_we), 64'd0);
      chk("rst_ovf", 64'(a_ovf), 64'd0);
      rst_n = 1'b1;
      step();

      // Single word from idle
      a_drive(40'h80_0000_0001, 40'h00_0000_0003, 2'b11, 1'b1);
      step();
      a_load = 1'b0;
      chk("s1_outready", 64'(a_outready), 64'd1);
      chk("s1_wsen", 64'(a_wsen), 64'h3);
      chk("s1_first_sout", 64'(a_sout), 64'h1);
      repeat (39) step();
      chk("s1_word_end", 64'(a_we), 64'd1);
      chk("s1_last_sout", 64'(a_sout), 64'h3);
      step();
      chk("s1_outready_off", 64'(a_outready), 64'd0);

      // Two words five cycles apart run back to back
      step();
      a_drive(40'h12_3456_789A, 40'hA5_5A5A_0F0F, 2'b11, 1'b1);
      step();
      a_load = 1'b0;
      hi = 0;
      for (int c = 0; c <= 80; c++) begin
         if (c < 80) hi += int'(a_outready);
         else chk("s2_outready_after", 64'(a_outready), 64'd0);
         if (c == 4) a_drive(40'hFF_0000_00FF, 40'h01_8000_0001, 2'b11, 1'b1);
         if (c == 5) begin
            a_load = 1'b0;
            chk("s2_ready_buffered", 64'(a_ready), 64'd0);
         end
         if (c == 39) chk("s2_word_end_40", 64'(a_we), 64'd1);
         if (c == 40) chk("s2_ready_after_move", 64'(a_ready), 64'd1);
         if (c == 79) chk("s2_word_end_80", 64'(a_we), 64'd1);
         step();
      end
      chk("s2_outready_run", 64'(hi), 64'd80);

      // Right channel disabled
      a_drive(40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 2'b01, 1'b1);
      step();
      a_load = 1'b0;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (a_wsen !== 2'b01 || a_sout[1] !== 1'b0) bad++;
         step();
      end
      chk("s3_ch1_quiet", 64'(bad), 64'd0);
      step();

      // LSB-first 16-bit instance
      b_drive(16'h0001);
      step();
      b_load = 1'b0;
      first = b_sout[0];
      ones = 0;
      for (int c = 0; c < 16; c++) begin
         ones += int'(b_sout[0]);
         step();
      end
      chk("s4_first_bit", 64'(first), 64'd1);
      chk("s4_one_count", 64'(ones), 64'd1);
      chk("s4_outready_off", 64'(b_outready), 64'd0);

      // Reset in the middle of a word
      a_drive(40'h12_3456_789A, 40'hA5_5A5A_0F0F, 2'b11, 1'b1);
      step();
      a_load = 1'b0;
      repeat (20) step();
      chk("s5_mid_word", 64'(a_outready), 64'd1);
      rst_n = 1'b0;
      #1;
      qa.delete();
      chk("s5_rst_ready", 64'(a_ready), 64'd1);
      chk("s5_rst_outready", 64'(a_outready), 64'd0);
      chk("s5_rst_sout", 64'(a_sout), 64'd0);
      chk("s5_rst_wsen", 64'(a_wsen), 64'd0);
      chk("s5_rst_word_end", 64'(a_we), 64'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      a_drive(40'h80_0000_0000, 40'h00_0000_0001, 2'b11, 1'b1);
      step();
      a_load = 1'b0;
      chk("s5_restart_sout", 64'(a_sout), 64'h1);
      repeat (39) step();
      chk("s5_restart_word_end", 64'(a_we), 64'd1);
      chk("s5_restart_last_sout", 64'(a_sout), 64'h2);
      repeat (2) step();

      // Overrun: third load while the buffer is full is dropped
      a_drive(40'h00_0000_FFFF, 40'hFF_FF00_0000, 2'b11, 1'b1);
      step();
      a_drive(40'h55_5555_5555, 40'hAA_AAAA_AAAA, 2'b10, 1'b1);
      step();
      chk("s6_ready_full", 64'(a_ready), 64'd0);
      a_drive(40'hDE_ADBE_EF00, 40'h12_1212_1212, 2'b11, 1'b0);
      step();
      a_load = 1'b0;
      chk("s6_ovf_set", 64'(a_ovf), 64'(OVF_ON));
      a_ovf_clr = 1'b1;
      step();
      a_ovf_clr = 1'b0;
      chk("s6_ovf_cleared", 64'(a_ovf), 64'd0);
      repeat (80) step();
      chk("s6_outready_off", 64'(a_outready), 64'd0);
      chk("s6_ovf_idle", 64'(a_ovf), 64'd0);

      repeat (3) step();
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
